// File: rtl/pe_pkg.sv
// Shared definitions for the systolic processing elements: accumulator FSM
// states, default accumulator sizing and saturation bounds.
package pe_pkg;

  typedef enum logic [0:0] {
    PE_IDLE  = 1'b0,
    PE_ACCUM = 1'b1
  } pe_state_e;

  localparam int unsigned PE_MAX_W     = 256;
  localparam int unsigned PE_ACC_GUARD = 8;

  function automatic int unsigned pe_acc_width(input int unsigned dw);
    return (2 * dw) + PE_ACC_GUARD;
  endfunction

  // Largest representable value of a width-bit accumulator, zero-padded to PE_MAX_W.
  function automatic logic [PE_MAX_W-1:0] sat_max(input int unsigned width, input bit is_signed);
    logic [PE_MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < PE_MAX_W; i++) begin
      if (i < width) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    if (is_signed && (width > 0)) begin
      v[width-1] = 1'b0;
    end else begin
      v = v;
    end
    return v;
  endfunction

  function automatic logic [PE_MAX_W-1:0] sat_min(input int unsigned width, input bit is_signed);
    logic [PE_MAX_W-1:0] v;
    v = '0;
    if (is_signed && (width > 0)) begin
      v[width-1] = 1'b1;
    end else begin
      v = v;
    end
    return v;
  endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Combinational extend + multiply + accumulate with optional saturation.
// Produces the new accumulator value and an overflow flag for one MAC step.
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = pe_acc_width(DATA_WIDTH),
  parameter bit          SIGNED     = 1'b0,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [ACC_WIDTH-1:0]  i_base,
  output logic [ACC_WIDTH-1:0]  o_sum,
  output logic                  o_ovf
);

  localparam int unsigned PW    = 2 * DATA_WIDTH;
  localparam int unsigned XW    = ACC_WIDTH + 1;
  localparam int unsigned EXT_W = XW - PW;

  localparam logic [PE_MAX_W-1:0] LP_MAX = sat_max(ACC_WIDTH, SIGNED);
  localparam logic [PE_MAX_W-1:0] LP_MIN = sat_min(ACC_WIDTH, SIGNED);

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_ext;
  logic [PW-1:0] w_prod;
  logic [XW-1:0] w_prod_x;
  logic [XW-1:0] w_base_x;
  logic [XW-1:0] w_sum_x;
  logic          w_ovf;

  // Operands are widened to the full product width so the low half of an
  // unsigned multiply is the correct two's-complement product as well.
  always_comb begin
    w_a_ext  = {{DATA_WIDTH{SIGNED & i_a[DATA_WIDTH-1]}}, i_a};
    w_b_ext  = {{DATA_WIDTH{SIGNED & i_b[DATA_WIDTH-1]}}, i_b};
    w_prod   = w_a_ext * w_b_ext;
    w_prod_x = {{EXT_W{SIGNED & w_prod[PW-1]}}, w_prod};
    w_base_x = {SIGNED & i_base[ACC_WIDTH-1], i_base};
    w_sum_x  = w_base_x + w_prod_x;
    if (SIGNED) begin
      w_ovf = w_sum_x[XW-1] ^ w_sum_x[XW-2];
    end else begin
      w_ovf = w_sum_x[XW-1];
    end
    if (SATURATE && w_ovf) begin
      if (SIGNED && w_sum_x[XW-1]) begin
        o_sum = LP_MIN[ACC_WIDTH-1:0];
      end else begin
        o_sum = LP_MAX[ACC_WIDTH-1:0];
      end
    end else begin
      o_sum = w_sum_x[ACC_WIDTH-1:0];
    end
    o_ovf = w_ovf;
  end

endmodule

// File: rtl/pe_mac_tile.sv
// Systolic MAC processing element: forwards operands right/down, accumulates
// tiles framed by first/last markers and parks each result in a drain buffer.
module pe_mac_tile
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = pe_acc_width(DATA_WIDTH),
  parameter bit          SIGNED     = 1'b0,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] up_i,
  input  logic                  up_valid_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic                  left_valid_i,
  input  logic                  left_first_i,
  input  logic                  left_last_i,
  output logic [DATA_WIDTH-1:0] down_o,
  output logic                  down_valid_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic                  right_valid_o,
  output logic                  right_first_o,
  output logic                  right_last_o,
  output logic [ACC_WIDTH-1:0]  res_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  ovf_o,
  output logic                  res_lost_o,
  output logic                  busy_o
);

  pe_state_e             r_state;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic                  r_tile_ovf;
  logic                  r_busy;

  logic [DATA_WIDTH-1:0] r_down;
  logic                  r_down_valid;
  logic [DATA_WIDTH-1:0] r_right;
  logic                  r_right_valid;
  logic                  r_right_first;
  logic                  r_right_last;

  logic [ACC_WIDTH-1:0]  r_res;
  logic                  r_res_valid;
  logic                  r_res_ovf;
  logic                  r_res_lost;

  logic                  w_fire;
  logic                  w_base_zero;
  logic [ACC_WIDTH-1:0]  w_base;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_ovf;
  logic                  w_tile_ovf_nxt;
  logic                  w_drain;
  logic                  w_load;
  logic                  w_can_load;

  pe_mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SIGNED     (SIGNED),
    .SATURATE   (SATURATE)
  ) u_mac (
    .i_a    (left_i),
    .i_b    (up_i),
    .i_base (w_base),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  // A first marker or an idle accumulator starts a fresh tile from zero.
  always_comb begin
    w_fire      = en_i & left_valid_i & up_valid_i;
    w_base_zero = left_first_i | (r_state == PE_IDLE);
    if (w_base_zero) begin
      w_base         = '0;
      w_tile_ovf_nxt = w_ovf;
    end else begin
      w_base         = r_acc;
      w_tile_ovf_nxt = r_tile_ovf | w_ovf;
    end
    w_drain    = r_res_valid & res_ready_i;
    w_load     = w_fire & left_last_i;
    w_can_load = ~r_res_valid | w_drain;
  end

  // Operand forwarding to the neighbouring PEs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_down        <= '0;
      r_down_valid  <= 1'b0;
      r_right       <= '0;
      r_right_valid <= 1'b0;
      r_right_first <= 1'b0;
      r_right_last  <= 1'b0;
    end else if (en_i) begin
      r_down        <= up_i;
      r_down_valid  <= up_valid_i;
      r_right       <= left_i;
      r_right_valid <= left_valid_i;
      r_right_first <= left_first_i;
      r_right_last  <= left_last_i;
    end
  end

  // Accumulator FSM; only a fire moves it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= PE_IDLE;
      r_acc      <= '0;
      r_tile_ovf <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_fire) begin
      case (r_state)
        PE_IDLE, PE_ACCUM: begin
          if (left_last_i) begin
            r_state    <= PE_IDLE;
            r_acc      <= '0;
            r_tile_ovf <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            r_state    <= PE_ACCUM;
            r_acc      <= w_sum;
            r_tile_ovf <= w_tile_ovf_nxt;
            r_busy     <= 1'b1;
          end
        end
        default: begin
          r_state    <= PE_IDLE;
          r_acc      <= '0;
          r_tile_ovf <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Result buffer runs regardless of en_i so a stalled array still drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_res_lost  <= 1'b0;
    end else if (w_load && w_can_load) begin
      r_res       <= w_sum;
      r_res_valid <= 1'b1;
      r_res_ovf   <= w_tile_ovf_nxt;
    end else begin
      if (w_drain) begin
        r_res_valid <= 1'b0;
        r_res_ovf   <= 1'b0;
      end
      if (w_load) begin
        r_res_lost <= 1'b1;
      end
    end
  end

  assign down_o        = r_down;
  assign down_valid_o  = r_down_valid;
  assign right_o       = r_right;
  assign right_valid_o = r_right_valid;
  assign right_first_o = r_right_first;
  assign right_last_o  = r_right_last;
  assign res_o         = r_res;
  assign res_valid_o   = r_res_valid;
  assign ovf_o         = r_res_ovf;
  assign res_lost_o    = r_res_lost;
  assign busy_o        = r_busy;

endmodule
